// File: rtl/taichip_pin_link_if.sv
// taichip_pin_link_if: core-side byte streams of the pin link.
// The link drives the RX stream towards the core and accepts the TX stream
// from the core. Modport "slave" is the link side, "master" is the core side.
interface taichip_pin_link_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/taichip_pin_link.sv
// taichip_pin_link: chip-side responder for the Tiny Tapeout byte protocol.
// Host write strobes (uio_in[0]) push ui_in into an RX FIFO for the core.
// Host read-ack strobes (uio_in[3]) pop the TX FIFO whose head is shown on uo_out.
// Optional odd-parity checking of host writes is enabled by defining LINK_PARITY_EN.
module taichip_pin_link #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [7:0]           ui_in,
    input  logic [7:0]           uio_in,
    output logic [7:0]           uo_out,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe,
    taichip_pin_link_if.slave    link
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    // Registered pin samples and previous strobe values for edge detection
    logic [7:0] s_data;
    logic       s_wr, s_rd, s_par;
    logic       p_wr, p_rd;

    logic [7:0] rx_mem [DEPTH];
    logic [7:0] tx_mem [DEPTH];

    logic [PW-1:0] rx_wptr, rx_rptr, tx_wptr, tx_rptr;
    logic [PW-1:0] rx_wptr_n, rx_rptr_n, tx_wptr_n, tx_rptr_n;

    logic rx_valid_q, rx_full_q, tx_valid_q, tx_full_q;
    logic overflow_q, par_err_q;

    logic wr_edge, rd_edge, par_ok;
    logic rx_push, rx_pop, rx_ovf, par_bad;
    logic tx_push, tx_pop;

    // Full when the wrap bits differ but the index bits match
    function automatic logic ptr_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
        return (w[PW-1] != r[PW-1]) && (w[PW-2:0] == r[PW-2:0]);
    endfunction

    assign wr_edge = s_wr & ~p_wr & ena;
    assign rd_edge = s_rd & ~p_rd & ena;

`ifdef LINK_PARITY_EN
    assign par_ok  = ^{s_data, s_par};
    assign uio_oe  = 8'b0011_0110;
    logic unused_pins;
    assign unused_pins = ^{uio_in[7:5], uio_in[2:1]};
`else
    assign par_ok  = 1'b1;
    assign uio_oe  = 8'b0001_0110;
    logic unused_pins;
    assign unused_pins = ^{uio_in[7:4], uio_in[2:1], s_par};
`endif

    // Decide this cycle's FIFO operations and the resulting pointers
    always_comb begin
        rx_pop    = rx_valid_q & link.rx_ready;
        rx_push   = wr_edge & par_ok & (~rx_full_q | rx_pop);
        rx_ovf    = wr_edge & par_ok & rx_full_q & ~rx_pop;
        par_bad   = wr_edge & ~par_ok;
        tx_push   = link.tx_valid & ~tx_full_q;
        tx_pop    = rd_edge & tx_valid_q;
        rx_wptr_n = rx_wptr + PW'(rx_push);
        rx_rptr_n = rx_rptr + PW'(rx_pop);
        tx_wptr_n = tx_wptr + PW'(tx_push);
        tx_rptr_n = tx_rptr + PW'(tx_pop);
    end

    // Pin sampling, pointers, registered status flags and sticky errors
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_data     <= 8'h00;
            s_wr       <= 1'b0;
            s_rd       <= 1'b0;
            s_par      <= 1'b0;
            p_wr       <= 1'b0;
            p_rd       <= 1'b0;
            rx_wptr    <= '0;
            rx_rptr    <= '0;
            tx_wptr    <= '0;
            tx_rptr    <= '0;
            rx_valid_q <= 1'b0;
            rx_full_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_full_q  <= 1'b0;
            overflow_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            s_data     <= ui_in;
            s_wr       <= uio_in[0];
            s_rd       <= uio_in[3];
            s_par      <= uio_in[4];
            p_wr       <= s_wr;
            p_rd       <= s_rd;
            rx_wptr    <= rx_wptr_n;
            rx_rptr    <= rx_rptr_n;
            tx_wptr    <= tx_wptr_n;
            tx_rptr    <= tx_rptr_n;
            rx_valid_q <= (rx_wptr_n != rx_rptr_n);
            rx_full_q  <= ptr_full(rx_wptr_n, rx_rptr_n);
            tx_valid_q <= (tx_wptr_n != tx_rptr_n);
            tx_full_q  <= ptr_full(tx_wptr_n, tx_rptr_n);
            if (rx_ovf)  overflow_q <= 1'b1;
            if (par_bad) par_err_q  <= 1'b1;
        end
    end

    // FIFO storage; a full-FIFO push with a pop reuses the slot being popped
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr[PW-2:0]] <= s_data;
        if (tx_push) tx_mem[tx_wptr[PW-2:0]] <= link.tx_data;
    end

    // Heads read as zero when empty so nothing undefined reaches the pins
    assign uo_out        = tx_valid_q ? tx_mem[tx_rptr[PW-2:0]] : 8'h00;
    assign link.rx_data  = rx_valid_q ? rx_mem[rx_rptr[PW-2:0]] : 8'h00;
    assign link.rx_valid = rx_valid_q;
    assign link.tx_ready = ~tx_full_q;
    assign uio_out       = {2'b00, par_err_q, overflow_q, 1'b0, tx_valid_q, rx_full_q, 1'b0};

endmodule

// File: tb/tb_taichip_pin_link.sv
// tb_taichip_pin_link: directed self-checking bench for taichip_pin_link.
// Define LINK_PARITY_EN for both bench and design to cover the parity build.
module tb_taichip_pin_link;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests_run;
    int tests_failed;

    taichip_pin_link_if link ();

    taichip_pin_link #(.DEPTH_LOG2(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .link    (link.slave)
    );

`ifdef LINK_PARITY_EN
    localparam logic [7:0] OE_EXP = 8'h36;
`else
    localparam logic [7:0] OE_EXP = 8'h16;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clocks and land 1 ns after the last rising edge
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Host write: data set a cycle ahead, strobe 2 high / 2 low
    task automatic apply_stimulus(input logic [7:0] data, input logic par);
        ui_in     = data;
        uio_in[4] = par;
        cycles(1);
        uio_in[0] = 1'b1;
        cycles(2);
        uio_in[0] = 1'b0;
        cycles(2);
    endtask

    // Host read ack: strobe 2 high / 2 low
    task automatic read_ack();
        uio_in[3] = 1'b1;
        cycles(2);
        uio_in[3] = 1'b0;
        cycles(2);
    endtask

    // Core pops one RX byte with a one-clock ready pulse
    task automatic core_pop();
        link.rx_ready = 1'b1;
        cycles(1);
        link.rx_ready = 1'b0;
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        ena           = 1'b1;
        ui_in         = 8'h00;
        uio_in        = 8'h00;
        link.rx_ready = 1'b0;
        link.tx_data  = 8'h00;
        link.tx_valid = 1'b0;

        // Reset state
        cycles(3);
        rst_n = 1'b1;
        check_output("reset_uo_out",   uo_out,        8'h00);
        check_output("reset_uio_out",  uio_out,       8'h00);
        check_output("reset_rx_valid", link.rx_valid, 1'b0);
        check_output("reset_rx_data",  link.rx_data,  8'h00);
        check_output("reset_tx_ready", link.tx_ready, 1'b1);
        check_output("reset_uio_oe",   uio_oe,        OE_EXP);

        // Single write: visible exactly 2 clocks after the strobe rises
        ui_in = 8'hA5;
        cycles(1);
        uio_in[0] = 1'b1;
        cycles(1);
        check_output("wr_lat1_rx_valid", link.rx_valid, 1'b0);
        cycles(1);
        check_output("wr_lat2_rx_valid", link.rx_valid, 1'b1);
        check_output("wr_lat2_rx_data",  link.rx_data,  8'hA5);
        uio_in[0] = 1'b0;
        cycles(2);
        core_pop();
        check_output("wr_pop_rx_valid", link.rx_valid, 1'b0);

        // Overflow: four fit, fifth is dropped and flagged
        for (int i = 1; i <= 5; i++) begin
            apply_stimulus(8'(i), 1'b1);
            if (i == 3) check_output("ovf_full_after3", uio_out[1], 1'b0);
            if (i == 4) begin
                check_output("ovf_full_after4", uio_out[1], 1'b1);
                check_output("ovf_flag_after4", uio_out[4], 1'b0);
            end
        end
        check_output("ovf_flag_after5", uio_out[4], 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check_output("ovf_drain_valid", link.rx_valid, 1'b1);
            check_output("ovf_drain_data",  link.rx_data,  8'(i));
            core_pop();
        end
        check_output("ovf_drained_valid", link.rx_valid, 1'b0);
        check_output("ovf_drained_full",  uio_out[1],    1'b0);
        check_output("ovf_flag_sticky",   uio_out[4],    1'b1);

        // Push and pop on a full RX FIFO in the same cycle
        for (int i = 0; i < 4; i++) apply_stimulus(8'(8'h11 + i), 1'b1);
        ui_in = 8'h15;
        cycles(1);
        uio_in[0] = 1'b1;
        cycles(1);
        link.rx_ready = 1'b1;
        cycles(1);
        link.rx_ready = 1'b0;
        check_output("simul_full_kept", uio_out[1],   1'b1);
        check_output("simul_head",      link.rx_data, 8'h12);
        uio_in[0] = 1'b0;
        cycles(2);
        for (int i = 0; i < 4; i++) begin
            check_output("simul_drain_data", link.rx_data, 8'(8'h12 + i));
            core_pop();
        end
        check_output("simul_drained_valid", link.rx_valid, 1'b0);

        // TX path
        link.tx_data  = 8'h3C;
        link.tx_valid = 1'b1;
        cycles(1);
        check_output("tx_first_uo_out", uo_out,     8'h3C);
        check_output("tx_first_valid",  uio_out[2], 1'b1);
        link.tx_data = 8'hC3;
        cycles(1);
        link.tx_valid = 1'b0;
        check_output("tx_second_head", uo_out, 8'h3C);
        read_ack();
        check_output("tx_rd1_uo_out", uo_out,     8'hC3);
        read_ack();
        check_output("tx_rd2_uo_out", uo_out,     8'h00);
        check_output("tx_rd2_valid",  uio_out[2], 1'b0);
        read_ack();
        check_output("tx_rd3_uo_out", uo_out,        8'h00);
        check_output("tx_rd3_valid",  uio_out[2],    1'b0);
        check_output("tx_rd3_ready",  link.tx_ready, 1'b1);

        // TX full: the fifth offered byte is held off
        link.tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            link.tx_data = 8'(8'hB0 + i);
            cycles(1);
        end
        check_output("tx_full_ready", link.tx_ready, 1'b0);
        link.tx_data = 8'hEE;
        cycles(1);
        link.tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_output("tx_full_drain", uo_out, 8'(8'hB0 + i));
            read_ack();
        end
        check_output("tx_full_empty", uo_out, 8'h00);

        // Enable gating: no push while disabled, none when enabled mid-strobe
        ena   = 1'b0;
        ui_in = 8'h77;
        cycles(1);
        uio_in[0] = 1'b1;
        cycles(2);
        check_output("ena_off_no_push", link.rx_valid, 1'b0);
        ena = 1'b1;
        cycles(2);
        check_output("ena_on_no_push", link.rx_valid, 1'b0);
        uio_in[0] = 1'b0;
        cycles(2);
        check_output("ena_after_no_push", link.rx_valid, 1'b0);

        // Parity: 0x03 with parity bit 1 is odd overall; with 0 it is even
        apply_stimulus(8'h03, 1'b1);
        check_output("par_good_valid", link.rx_valid, 1'b1);
        check_output("par_good_data",  link.rx_data,  8'h03);
        core_pop();
        apply_stimulus(8'h03, 1'b0);
`ifdef LINK_PARITY_EN
        check_output("par_bad_valid", link.rx_valid, 1'b0);
        check_output("par_bad_flag",  uio_out[5],    1'b1);
        cycles(3);
        check_output("par_flag_sticky", uio_out[5], 1'b1);
`else
        check_output("par_off_valid", link.rx_valid, 1'b1);
        check_output("par_off_flag",  uio_out[5],    1'b0);
        core_pop();
`endif

        // Reset in the middle of traffic
        link.tx_data  = 8'h5A;
        link.tx_valid = 1'b1;
        cycles(1);
        link.tx_valid = 1'b0;
        apply_stimulus(8'h66, 1'b1);
        ui_in = 8'h99;
        uio_in[0] = 1'b1;
        rst_n = 1'b0;
        cycles(1);
        check_output("midrst_uo_out",   uo_out,        8'h00);
        check_output("midrst_uio_out",  uio_out,       8'h00);
        check_output("midrst_rx_valid", link.rx_valid, 1'b0);
        check_output("midrst_tx_ready", link.tx_ready, 1'b1);
        check_output("midrst_uio_oe",   uio_oe,        OE_EXP);
        uio_in[0] = 1'b0;
        rst_n = 1'b1;
        cycles(3);
        check_output("postrst_rx_valid", link.rx_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/taichip_pin_link.md
# taichip_pin_link

Pin-level link responder that sits directly behind the `tt_um_ashwin_taichip` top-level pins. It is the chip-side end of the byte protocol the cocotb host drives through `ui_in`/`uio_in`. The block decodes host write strobes into an RX byte FIFO for the core and presents core response bytes from a TX FIFO on `uo_out`, which the host acknowledges with a read strobe. It converts the raw Tiny Tapeout pin interface into two valid/ready byte streams.

## Interface
Parameters:
- `DEPTH_LOG2`, default 2: log2 of each FIFO depth, giving 4 entries.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `ena`  in  1  design-selected; when low, strobe edges are not acted on.
- `ui_in`  in  8  host write data.
- `uio_in`  in  8  bit0 = WR strobe, bit3 = RD ack strobe, bit4 = parity (feature only), other bits ignored.
- `uo_out`  out  8  TX FIFO head byte; 0 when TX is empty.
- `uio_out`  out  8  bit1 = RX full, bit2 = TX valid, bit4 = RX overflow (sticky), bit5 = parity error (sticky, feature only), other bits 0.
- `uio_oe`  out  8  constant 8'b0001_0110, or 8'b0011_0110 with the parity feature.
- `rx_data`  out  8  RX FIFO head byte.
- `rx_valid`  out  1  RX FIFO not empty.
- `rx_ready`  in  1  core pops RX when `rx_valid & rx_ready`.
- `tx_data`  in  8  core response byte.
- `tx_valid`  in  1  core pushes when `tx_valid & tx_ready`.
- `tx_ready`  out  1  TX FIFO not full.

## Operation
- Input stage: `ui_in`, `uio_in[0]`, `uio_in[3]` and `uio_in[4]` are registered every cycle into `s_*` registers. A second register `p_*` holds the previous strobe values.
- Write edge: `s_wr & ~p_wr & ena`. On a write edge, `s_data` is pushed into the RX FIFO.
- RX full on write edge: the byte is dropped and the overflow flag (`uio_out[4]`) is set. The flag clears only on reset.
- Simultaneous RX push and pop: both take effect in the same cycle. If the FIFO was full, the push is accepted because the pop frees a slot. Occupancy is unchanged.
- Read edge: `s_rd & ~p_rd & ena`. On a read edge with TX non-empty, the TX FIFO pops. A read edge while TX is empty is ignored.
- Simultaneous TX push and pop: both succeed. `tx_ready` reflects occupancy before the edge.
- FIFO pointers are `DEPTH_LOG2+1` bits and wrap modulo 2·depth. Full and empty are decided by comparing the MSB and the remaining pointer bits.
- When `ena` = 0: input and previous registers keep updating, so no stale edge fires when `ena` returns high. No host-side push or pop occurs. The core-side ports remain functional.
- Reset (`rst_n` = 0 at a clock edge), including mid-transfer: both FIFOs are emptied, all `s_*`/`p_*` registers are cleared and the sticky flags are cleared. Every output reads 0 except `uio_oe` (constant) and `tx_ready` = 1.

## Timing
- Host write: the pin rises before edge N, `s_wr` = 1 after N, the push happens at N+1, and `rx_valid` = 1 after N+1. Latency is 2 clocks.
- The host must hold `ui_in` stable from the cycle before the strobe rises until edge N.
- Core push to `uo_out`/`uio_out[2]`: visible 1 clock after the push edge.
- Host read ack: the pin rises before edge N and the pop happens at N+1. The next byte, or 0 if empty, appears on `uo_out` after N+1.
- Minimum strobe period: 4 clocks (2 high, 2 low). Each rising edge produces exactly one push or pop.
- `rx_valid`, `tx_ready` and the status bits come directly from registers.

## Configuration
- `LINK_PARITY_EN` defined:
  - `uio_in[4]` carries odd parity over `ui_in`.
  - A write edge whose `s_data`/`s_par` has even total parity is dropped and sets sticky `uio_out[5]`.
  - `uio_oe[5]` = 1.
- `LINK_PARITY_EN` undefined:
  - `uio_in[4]` is ignored.
  - `uio_out[5]` = 0.
  - `uio_oe` = 8'b0001_0110.
  - All writes are accepted, subject only to the full check.

## Test plan
- Reset check: hold `rst_n` low 3 clocks, then release. Expect `uo_out` = 0x00, `uio_out` = 0x00, `rx_valid` = 0, `tx_ready` = 1, `uio_oe` = 0x16 (0x36 with parity).
- Single write: set `ui_in` = 0xA5 and pulse WR 2 high/2 low. Expect `rx_valid` = 1 and `rx_data` = 0xA5 exactly 2 clocks after the rising edge. Pulsing `rx_ready` for 1 clock then gives `rx_valid` = 0.
- Overflow: write 0x01–0x05 with `rx_ready` = 0. Expect `uio_out[1]` = 1 after the 4th write and `uio_out[4]` = 1 after the 5th. Draining yields 0x01–0x04 only.
- TX path: the core pushes 0x3C then 0xC3. Expect `uo_out` = 0x3C and `uio_out[2]` = 1. One RD pulse gives `uo_out` = 0xC3. A second gives `uo_out` = 0x00 and `uio_out[2]` = 0. A third RD pulse changes nothing.
- Enable gating: with `ena` = 0, pulse WR with 0x77. Expect no push. Raise `ena` while WR is still high: expect no push.
- Parity (`LINK_PARITY_EN`): write 0x03 with `uio_in[4]` = 1 and expect it accepted. Write 0x03 with `uio_in[4]` = 0 and expect it dropped with `uio_out[5]` = 1 until reset.
